apb_initiator_module: RTL and testbench

//  Bus initiator that drives the accelerator register file over its APB-style slave port.

---
 rtl/apb_initiator_module_pkg.sv | 24 ++
 rtl/apb_timeout_counter_module.sv | 29 ++
 rtl/apb_initiator_module.sv | 129 ++++++++++++
 tb/tb_apb_initiator_module.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/apb_initiator_module_pkg.sv
// Shared definitions for the APB initiator: register map offsets, FSM encoding
// and the element-count helper.
package apb_initiator_module_pkg;

  localparam logic [4:0] REG_CONTROL   = 5'h00;
  localparam logic [4:0] REG_OPERAND_A = 5'h04;
  localparam logic [4:0] REG_OPERAND_B = 5'h08;
  localparam logic [4:0] REG_FLAGS     = 5'h0C;
  localparam logic [4:0] REG_SP        = 5'h10;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETUP  = 2'd1,
    ST_ACCESS = 2'd2,
    ST_RESP   = 2'd3
  } apb_state_e;

  // Number of data elements carried on one bus beat (one strobe bit each).
  function automatic int unsigned max_dim(input int unsigned bus_width,
                                          input int unsigned data_width);
    return bus_width / data_width;
  endfunction

endpackage

// File: rtl/apb_timeout_counter_module.sv
// Counts ACCESS cycles without pready; flags the cycle in which the limit is hit.
// A limit of 0 disables the timeout.
module apb_timeout_counter_module #(
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic clear_i,
  input  logic enable_i,
  output logic expired_c
);

  localparam int unsigned CNT_W = (TIMEOUT_CYCLES == 0) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] LAST = (TIMEOUT_CYCLES == 0) ? '0 : CNT_W'(TIMEOUT_CYCLES - 1);

  logic [CNT_W-1:0] count_q;

  always_ff @(posedge clk_i) begin
    if (rst_i || clear_i) begin
      count_q <= '0;
    end else if (enable_i) begin
      count_q <= count_q + CNT_W'(1);
    end
  end

  // Asserted on the TIMEOUT_CYCLES-th stalled cycle so the FSM leaves on that edge.
  assign expired_c = (TIMEOUT_CYCLES != 0) && enable_i && (count_q == LAST);

endmodule

// File: rtl/apb_initiator_module.sv
// Single-outstanding APB initiator: takes one command, runs SETUP/ACCESS with a
// bounded wait, and returns read data or completion on the response port.
module apb_initiator_module
  import apb_initiator_module_pkg::*;
#(
  parameter  int unsigned DATA_WIDTH     = 32,
  parameter  int unsigned BUS_WIDTH      = 64,
  parameter  int unsigned ADDR_WIDTH     = 32,
  parameter  int unsigned TIMEOUT_CYCLES = 16,
  localparam int unsigned MAX_DIM        = max_dim(BUS_WIDTH, DATA_WIDTH)
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  cmd_valid_i,
  output logic                  cmd_ready_o,
  input  logic                  cmd_write_i,
  input  logic [ADDR_WIDTH-1:0] cmd_addr_i,
  input  logic [BUS_WIDTH-1:0]  cmd_data_i,
  input  logic [MAX_DIM-1:0]    cmd_strb_i,
  output logic                  rsp_valid_o,
  input  logic                  rsp_ready_i,
  output logic [BUS_WIDTH-1:0]  rsp_data_o,
  output logic                  rsp_error_o,
  output logic                  psel_o,
  output logic                  penable_o,
  output logic                  pwrite_o,
  output logic [ADDR_WIDTH-1:0] paddr_o,
  output logic [BUS_WIDTH-1:0]  pwdata_o,
  output logic [MAX_DIM-1:0]    pstrb_o,
  input  logic [BUS_WIDTH-1:0]  prdata_i,
  input  logic                  pready_i,
  input  logic                  pslverr_i
);

  apb_state_e            state_q, state_d;
  logic                  accept;
  logic                  expired;
  logic                  psel_d, penable_d, pwrite_d, rsp_valid_d, rsp_error_d;
  logic [ADDR_WIDTH-1:0] paddr_d;
  logic [BUS_WIDTH-1:0]  pwdata_d, rsp_data_d;
  logic [MAX_DIM-1:0]    pstrb_d;

  assign cmd_ready_o = (state_q == ST_IDLE) && !rst_i;
  assign accept      = cmd_valid_i && cmd_ready_o;

  apb_timeout_counter_module #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timeout (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .clear_i  (state_q != ST_ACCESS),
    .enable_i ((state_q == ST_ACCESS) && !pready_i),
    .expired_c(expired)
  );

  // Next state and next values of every registered output.
  always_comb begin
    state_d     = state_q;
    pwrite_d    = pwrite_o;
    paddr_d     = paddr_o;
    pwdata_d    = pwdata_o;
    pstrb_d     = pstrb_o;
    rsp_data_d  = rsp_data_o;
    rsp_error_d = rsp_error_o;

    unique case (state_q)
      ST_IDLE: begin
        if (accept) begin
          state_d  = ST_SETUP;
          paddr_d  = cmd_addr_i;
          pwrite_d = cmd_write_i;
          pwdata_d = cmd_write_i ? cmd_data_i : '0;
          pstrb_d  = cmd_write_i ? cmd_strb_i : '0;
        end
      end
      ST_SETUP: state_d = ST_ACCESS;
      ST_ACCESS: begin
        if (pready_i) begin
          state_d     = ST_RESP;
          rsp_error_d = pslverr_i;
          rsp_data_d  = (pwrite_o || pslverr_i) ? '0 : prdata_i;
        end else if (expired) begin
          state_d     = ST_RESP;
          rsp_error_d = 1'b1;
          rsp_data_d  = '0;
        end
      end
      ST_RESP: begin
        if (rsp_ready_i) begin
          state_d     = ST_IDLE;
          rsp_data_d  = '0;
          rsp_error_d = 1'b0;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    psel_d      = (state_d == ST_SETUP) || (state_d == ST_ACCESS);
    penable_d   = (state_d == ST_ACCESS);
    rsp_valid_d = (state_d == ST_RESP);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= ST_IDLE;
      psel_o      <= 1'b0;
      penable_o   <= 1'b0;
      pwrite_o    <= 1'b0;
      paddr_o     <= '0;
      pwdata_o    <= '0;
      pstrb_o     <= '0;
      rsp_valid_o <= 1'b0;
      rsp_data_o  <= '0;
      rsp_error_o <= 1'b0;
    end else begin
      state_q     <= state_d;
      psel_o      <= psel_d;
      penable_o   <= penable_d;
      pwrite_o    <= pwrite_d;
      paddr_o     <= paddr_d;
      pwdata_o    <= pwdata_d;
      pstrb_o     <= pstrb_d;
      rsp_valid_o <= rsp_valid_d;
      rsp_data_o  <= rsp_data_d;
      rsp_error_o <= rsp_error_d;
    end
  end

endmodule

// File: tb/tb_apb_initiator_module.sv
// Directed bench for apb_initiator_module: a vector table of single transactions
// plus hand-written timeout, backpressure and mid-transaction reset sequences.
module tb_apb_initiator_module;
  import apb_initiator_module_pkg::*;

  localparam int unsigned AW = 32;
  localparam int unsigned BW = 64;
  localparam int unsigned MD = 2;
  localparam int unsigned TO = 16;

  logic          clk = 1'b0;
  logic          rst_i;
  logic          cmd_valid_i, cmd_ready_o, cmd_write_i;
  logic [AW-1:0] cmd_addr_i;
  logic [BW-1:0] cmd_data_i;
  logic [MD-1:0] cmd_strb_i;
  logic          rsp_valid_o, rsp_ready_i, rsp_error_o;
  logic [BW-1:0] rsp_data_o;
  logic          psel_o, penable_o, pwrite_o;
  logic [AW-1:0] paddr_o;
  logic [BW-1:0] pwdata_o;
  logic [MD-1:0] pstrb_o;
  logic [BW-1:0] prdata_i;
  logic          pready_i, pslverr_i;

  int tests_run    = 0;
  int tests_failed = 0;

  typedef struct {
    logic          write;
    logic [AW-1:0] addr;
    logic [BW-1:0] data;
    logic [MD-1:0] strb;
    logic [BW-1:0] prdata;
    int            waits;
    logic          slverr;
    logic [BW-1:0] exp_data;
    logic          exp_err;
  } vec_t;

  vec_t vecs[6];

  apb_initiator_module #(
    .DATA_WIDTH(32), .BUS_WIDTH(BW), .ADDR_WIDTH(AW), .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk_i(clk), .rst_i(rst_i),
    .cmd_valid_i(cmd_valid_i), .cmd_ready_o(cmd_ready_o), .cmd_write_i(cmd_write_i),
    .cmd_addr_i(cmd_addr_i), .cmd_data_i(cmd_data_i), .cmd_strb_i(cmd_strb_i),
    .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready_i),
    .rsp_data_o(rsp_data_o), .rsp_error_o(rsp_error_o),
    .psel_o(psel_o), .penable_o(penable_o), .pwrite_o(pwrite_o),
    .paddr_o(paddr_o), .pwdata_o(pwdata_o), .pstrb_o(pstrb_o),
    .prdata_i(prdata_i), .pready_i(pready_i), .pslverr_i(pslverr_i)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic drive_cmd(input logic w, input logic [AW-1:0] a,
                           input logic [BW-1:0] d, input logic [MD-1:0] s);
    cmd_valid_i = 1'b1;
    cmd_write_i = w;
    cmd_addr_i  = a;
    cmd_data_i  = d;
    cmd_strb_i  = s;
  endtask

  // Scramble command inputs after acceptance to prove they were latched.
  task automatic drop_cmd();
    cmd_valid_i = 1'b0;
    cmd_write_i = ~cmd_write_i;
    cmd_addr_i  = '1;
    cmd_data_i  = 64'hBAD0_BAD0_BAD0_BAD0;
    cmd_strb_i  = ~cmd_strb_i;
  endtask

  task automatic release_rsp();
    rsp_ready_i = 1'b1;
    @(negedge clk);
    rsp_ready_i = 1'b0;
    chk("rsp_drop", 64'(rsp_valid_o), 64'd0);
    chk("idle_ready", 64'(cmd_ready_o), 64'd1);
  endtask

  task automatic run_vec(input vec_t v);
    logic [BW-1:0] exp_wd;
    logic [MD-1:0] exp_st;
    exp_wd = v.write ? v.data : '0;
    exp_st = v.write ? v.strb : '0;
    @(negedge clk);
    chk("pre_ready", 64'(cmd_ready_o), 64'd1);
    drive_cmd(v.write, v.addr, v.data, v.strb);
    @(negedge clk);
    drop_cmd();
    chk("setup_phase", 64'({psel_o, penable_o, rsp_valid_o}), 64'b100);
    chk("setup_addr", 64'(paddr_o), 64'(v.addr));
    @(negedge clk);
    for (int w = 0; w <= v.waits; w++) begin
      chk("access_phase", 64'({psel_o, penable_o, rsp_valid_o}), 64'b110);
      chk("access_addr", 64'(paddr_o), 64'(v.addr));
      chk("access_pwrite", 64'(pwrite_o), 64'(v.write));
      chk("access_pwdata", pwdata_o, exp_wd);
      chk("access_pstrb", 64'(pstrb_o), 64'(exp_st));
      pready_i  = (w == v.waits);
      prdata_i  = (w == v.waits) ? v.prdata : ~v.prdata;
      pslverr_i = (w == v.waits) ? v.slverr : 1'b0;
      @(negedge clk);
    end
    pready_i  = 1'b0;
    pslverr_i = 1'b0;
    prdata_i  = 64'h5A5A_5A5A_5A5A_5A5A;
    chk("rsp_phase", 64'({psel_o, penable_o, rsp_valid_o}), 64'b001);
    chk("rsp_data", rsp_data_o, v.exp_data);
    chk("rsp_error", 64'(rsp_error_o), 64'(v.exp_err));
    release_rsp();
  endtask

  initial begin
    vecs[0] = '{1'b1, 32'(REG_CONTROL), 64'h1, 2'b11, 64'h0, 0, 1'b0, 64'h0, 1'b0};
    vecs[1] = '{1'b0, 32'(REG_OPERAND_A), 64'hFFFF, 2'b11, 64'h0000_0005_0000_0003, 3, 1'b0,
                64'h0000_0005_0000_0003, 1'b0};
    vecs[2] = '{1'b0, 32'h14, 64'h0, 2'b00, 64'hDEAD_BEEF_0000_1111, 0, 1'b1, 64'h0, 1'b1};
    vecs[3] = '{1'b1, 32'(REG_FLAGS), 64'hFFFF, 2'b00, 64'h0, 1, 1'b1, 64'h0, 1'b1};
    vecs[4] = '{1'b0, 32'(REG_SP), 64'h0, 2'b01, 64'h1234_5678_9ABC_DEF0, 0, 1'b0,
                64'h1234_5678_9ABC_DEF0, 1'b0};
    vecs[5] = '{1'b1, 32'(REG_OPERAND_B), 64'hCAFE_0000_0000_BEEF, 2'b10, 64'hFFFF_FFFF_FFFF_FFFF,
                2, 1'b0, 64'h0, 1'b0};

    rst_i = 1'b1; cmd_valid_i = 1'b0; cmd_write_i = 1'b0; cmd_addr_i = '0;
    cmd_data_i = '0; cmd_strb_i = '0; rsp_ready_i = 1'b0;
    prdata_i = '0; pready_i = 1'b0; pslverr_i = 1'b0;

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_cmd_ready", 64'(cmd_ready_o), 64'd0);
    chk("rst_apb_ctrl", 64'({psel_o, penable_o, pwrite_o}), 64'd0);
    chk("rst_paddr", 64'(paddr_o), 64'd0);
    chk("rst_pwdata", pwdata_o, 64'd0);
    chk("rst_pstrb", 64'(pstrb_o), 64'd0);
    chk("rst_rsp", 64'({rsp_valid_o, rsp_error_o}), 64'd0);
    chk("rst_rsp_data", rsp_data_o, 64'd0);
    rst_i = 1'b0;
    #1 chk("post_rst_ready", 64'(cmd_ready_o), 64'd1);

    foreach (vecs[i]) run_vec(vecs[i]);

    // Timeout: pready never arrives, response after 16 stalled ACCESS cycles
    @(negedge clk);
    drive_cmd(1'b0, 32'(REG_OPERAND_B), 64'h0, 2'b00);
    @(negedge clk);
    drop_cmd();
    prdata_i = 64'h7777_7777_7777_7777;
    chk("to_setup", 64'({psel_o, penable_o}), 64'b10);
    for (int i = 0; i < int'(TO); i++) begin
      @(negedge clk);
      chk("to_access", 64'({psel_o, penable_o, rsp_valid_o}), 64'b110);
    end
    @(negedge clk);
    chk("to_rsp_phase", 64'({psel_o, penable_o, rsp_valid_o}), 64'b001);
    chk("to_rsp_error", 64'(rsp_error_o), 64'd1);
    chk("to_rsp_data", rsp_data_o, 64'd0);
    release_rsp();

    // Backpressure: response held, new command ignored until released
    @(negedge clk);
    drive_cmd(1'b0, 32'(REG_OPERAND_A), 64'h0, 2'b00);
    @(negedge clk);
    drop_cmd();
    @(negedge clk);
    pready_i = 1'b1; prdata_i = 64'hAAAA_0000_BBBB_0001;
    @(negedge clk);
    pready_i = 1'b0; prdata_i = 64'h1111_1111_1111_1111; pslverr_i = 1'b1;
    drive_cmd(1'b0, 32'(REG_OPERAND_B), 64'h0, 2'b00);
    for (int i = 0; i < 5; i++) begin
      chk("bp_hold_valid", 64'({rsp_valid_o, psel_o, cmd_ready_o}), 64'b100);
      chk("bp_hold_data", rsp_data_o, 64'hAAAA_0000_BBBB_0001);
      chk("bp_hold_error", 64'(rsp_error_o), 64'd0);
      @(negedge clk);
    end
    pslverr_i = 1'b0;
    chk("bp_still_valid", 64'(rsp_valid_o), 64'd1);
    rsp_ready_i = 1'b1;
    @(negedge clk);
    rsp_ready_i = 1'b0;
    chk("bp_released", 64'({rsp_valid_o, cmd_ready_o, psel_o}), 64'b010);
    @(negedge clk);
    drop_cmd();
    chk("bp_next_setup", 64'({psel_o, penable_o}), 64'b10);
    chk("bp_next_addr", 64'(paddr_o), 64'(REG_OPERAND_B));
    chk("bp_next_pwrite", 64'(pwrite_o), 64'd0);
    @(negedge clk);
    // rsp_ready already high when the response appears
    pready_i = 1'b1; prdata_i = 64'h0BAD_F00D_0000_0042; rsp_ready_i = 1'b1;
    @(negedge clk);
    pready_i = 1'b0;
    chk("early_ready_rsp", 64'(rsp_valid_o), 64'd1);
    chk("early_ready_data", rsp_data_o, 64'h0BAD_F00D_0000_0042);
    @(negedge clk);
    rsp_ready_i = 1'b0;
    chk("early_ready_drop", 64'({rsp_valid_o, cmd_ready_o}), 64'b01);

    // Reset during ACCESS aborts without a response
    drive_cmd(1'b1, 32'(REG_CONTROL), 64'hFF, 2'b11);
    @(negedge clk);
    drop_cmd();
    @(negedge clk);
    chk("rst_mid_access", 64'({psel_o, penable_o}), 64'b11);
    rst_i = 1'b1;
    @(negedge clk);
    chk("rst_mid_apb", 64'({psel_o, penable_o, rsp_valid_o}), 64'b000);
    chk("rst_mid_ready", 64'(cmd_ready_o), 64'd0);
    chk("rst_mid_paddr", 64'(paddr_o), 64'd0);
    rst_i = 1'b0;
    #1 chk("rst_mid_ready_after", 64'(cmd_ready_o), 64'd1);
    pready_i = 1'b1;
    repeat (2) @(negedge clk);
    pready_i = 1'b0;
    chk("rst_mid_no_rsp", 64'({rsp_valid_o, psel_o}), 64'b00);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
